// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order after a power-on stretch, with
// software-triggered re-sequencing and registered done/busy/ack status.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  rst_done_o,
  output logic                  busy_o,
  output logic                  sw_rst_ack_o
);

  // state   | meaning
  // STRETCH | power-on stretch before stage 0 release
  // GAP     | waiting GAP_CYCLES before releasing stage r_idx
  // FINAL   | last stage released, done rises on the next edge
  // DONE    | all stages released, accepting software requests

  localparam int MAX_CYC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_STRETCH = 2'd0,
    ST_GAP     = 2'd1,
    ST_FINAL   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_stage;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_ack;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic                  w_done_nxt;
  logic                  w_ack_nxt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_STRETCH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stage <= '1;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_stage <= w_stage_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= ~w_done_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage;
    w_done_nxt  = r_done;
    w_ack_nxt   = 1'b0;
    unique case (r_state)
      ST_STRETCH: begin
        if (r_cnt == STRETCH_LAST) begin
          w_cnt_nxt      = '0;
          w_stage_nxt[0] = 1'b0;
          if (NUM_STAGES > 1) begin
            w_state_nxt = ST_GAP;
            w_idx_nxt   = IW'(1);
          end else begin
            w_state_nxt = ST_FINAL;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          // Loop decode keeps the index select legal for any NUM_STAGES.
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (IW'(k) == r_idx) w_stage_nxt[k] = 1'b0;
          end
          if (r_idx == LAST_IDX) w_state_nxt = ST_FINAL;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_FINAL: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (sw_rst_req_i) begin
          w_stage_nxt = '1;
          w_done_nxt  = 1'b0;
          w_ack_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_STRETCH;
        end
      end
      default: w_state_nxt = ST_STRETCH;
    endcase
  end

  assign stage_rst_o  = r_stage;
  assign rst_done_o   = r_done;
  assign busy_o       = r_busy;
  assign sw_rst_ack_o = r_ack;

endmodule
